// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the clock subsystem.
//   ps_state_t          - phase-shift sequencer states
//   PS_STEPS_PER_CYCLE  - default fine steps per MMCM output period
//   PS_TIMEOUT          - default psdone wait limit in psclk cycles
//   wrap_step()         - one fine step of phase position with modular wrap
package clock_pkg;

  typedef enum logic [2:0] {
    PS_IDLE   = 3'd0,
    PS_PULSE  = 3'd1,
    PS_WAIT   = 3'd2,
    PS_FINISH = 3'd3,
    PS_FAULT  = 3'd4
  } ps_state_t;

  localparam int unsigned PS_STEPS_PER_CYCLE = 32'd448;
  localparam int unsigned PS_TIMEOUT         = 32'd64;

  // Move pos one step up or down inside 0..period-1, wrapping at both ends.
  function automatic logic [31:0] wrap_step(input logic [31:0] pos,
                                            input logic        inc,
                                            input logic [31:0] period);
    logic [31:0] res;
    if (inc) begin
      if (pos >= period - 32'd1) begin
        res = 32'd0;
      end else begin
        res = pos + 32'd1;
      end
    end else begin
      if (pos == 32'd0) begin
        res = period - 32'd1;
      end else begin
        res = pos - 32'd1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mmcm_ps_ctrl.sv
// mmcm_ps_ctrl: MMCM dynamic fine phase-shift sequencer.
// Turns a signed step request into single-cycle psen pulses, each one
// handshaked against psdone, and tracks the phase position modulo one
// output period. Runs entirely in the psclk domain.
//
// Ports:
//   clk, rst_n           psclk and asynchronous active-low reset
//   locked               MMCM lock (synchronous to clk); loss aborts and zeroes position
//   req_valid/req_ready  request handshake, req_steps signed step count
//   clear_err            clears the sticky err_timeout flag and leaves FAULT
//   psen/psincdec/psdone MMCM phase-shift port
//   busy, done           request in progress / single-cycle completion pulse
//   err_timeout          sticky: psdone missing for TIMEOUT cycles
//   position             accumulated phase, 0..STEPS_PER_CYCLE-1
//
// Optional feature macro: MMCM_PS_CTRL_STATS_EN adds step_total (32-bit
// wrapping count of completed steps) and timeout_cnt (16-bit saturating
// count of timeout events).
module mmcm_ps_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned STEP_W          = 12,
  parameter int unsigned POS_W           = 16,
  parameter int unsigned STEPS_PER_CYCLE = PS_STEPS_PER_CYCLE,
  parameter int unsigned TIMEOUT         = PS_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [STEP_W-1:0] req_steps,
  input  logic              clear_err,
  output logic              psen,
  output logic              psincdec,
  input  logic              psdone,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
`ifdef MMCM_PS_CTRL_STATS_EN
  output logic [31:0]       step_total,
  output logic [15:0]       timeout_cnt,
`endif
  output logic [POS_W-1:0]  position
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  ps_state_t         state_r, state_s;
  logic [STEP_W-1:0] remaining_r, remaining_s;
  logic [STEP_W-1:0] req_mag_s;
  logic [STEP_W-1:0] rem_dec_s;
  logic              dir_r, dir_s;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_s;
  logic [POS_W-1:0]  position_r, position_s;
  logic [31:0]       pos_wrap_s;
  logic              err_r, err_s;
  logic              req_ready_r, psen_r, busy_r, done_r;
  logic              step_evt_s, to_evt_s;

  // Magnitude of the request; the most negative value maps to 2^(STEP_W-1),
  // which still fits STEP_W bits when read as unsigned.
  assign req_mag_s  = req_steps[STEP_W-1] ? (~req_steps + STEP_W'(1)) : req_steps;
  assign rem_dec_s  = remaining_r - STEP_W'(1);
  assign pos_wrap_s = wrap_step(32'(position_r), dir_r, 32'(STEPS_PER_CYCLE));

  // Next-state and datapath: lock loss overrides every state-specific action.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    dir_s       = dir_r;
    to_cnt_s    = to_cnt_r;
    position_s  = position_r;
    step_evt_s  = 1'b0;
    to_evt_s    = 1'b0;
    if (clear_err) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r;
    end

    if (!locked) begin
      // The MMCM reset that follows lock loss discards the phase.
      state_s     = PS_IDLE;
      remaining_s = '0;
      position_s  = '0;
    end else begin
      case (state_r)
        PS_IDLE: begin
          if (req_valid && req_ready_r) begin
            dir_s       = ~req_steps[STEP_W-1];
            remaining_s = req_mag_s;
            if (req_mag_s == '0) begin
              state_s = PS_FINISH;
            end else begin
              state_s = PS_PULSE;
            end
          end else begin
            state_s = PS_IDLE;
          end
        end
        PS_PULSE: begin
          to_cnt_s = '0;
          state_s  = PS_WAIT;
        end
        PS_WAIT: begin
          if (psdone) begin
            step_evt_s  = 1'b1;
            remaining_s = rem_dec_s;
            position_s  = pos_wrap_s[POS_W-1:0];
            if (rem_dec_s == '0) begin
              state_s = PS_FINISH;
            end else begin
              state_s = PS_PULSE;
            end
          end else if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
            // Setting the flag wins over a simultaneous clear request.
            err_s    = 1'b1;
            to_evt_s = 1'b1;
            state_s  = PS_FAULT;
          end else begin
            to_cnt_s = to_cnt_r + TO_W'(1);
          end
        end
        PS_FINISH: begin
          state_s = PS_IDLE;
        end
        PS_FAULT: begin
          if (clear_err) begin
            state_s = PS_IDLE;
          end else begin
            state_s = PS_FAULT;
          end
        end
        default: begin
          state_s = PS_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= PS_IDLE;
      remaining_r <= '0;
      dir_r       <= 1'b0;
      to_cnt_r    <= '0;
      position_r  <= '0;
      err_r       <= 1'b0;
      req_ready_r <= 1'b0;
      psen_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      dir_r       <= dir_s;
      to_cnt_r    <= to_cnt_s;
      position_r  <= position_s;
      err_r       <= err_s;
      req_ready_r <= (state_s == PS_IDLE) && locked;
      psen_r      <= (state_s == PS_PULSE);
      busy_r      <= (state_s != PS_IDLE);
      done_r      <= (state_s == PS_FINISH);
    end
  end

  assign req_ready   = req_ready_r;
  assign psen        = psen_r;
  assign psincdec    = dir_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err_timeout = err_r;
  assign position    = position_r;

`ifdef MMCM_PS_CTRL_STATS_EN
  logic [31:0] step_total_r;
  logic [15:0] timeout_cnt_r;

  // Statistics: wrapping step count and saturating timeout count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_total_r  <= 32'd0;
      timeout_cnt_r <= 16'd0;
    end else begin
      if (step_evt_s) begin
        step_total_r <= step_total_r + 32'd1;
      end else begin
        step_total_r <= step_total_r;
      end
      if (to_evt_s && (timeout_cnt_r != 16'hFFFF)) begin
        timeout_cnt_r <= timeout_cnt_r + 16'd1;
      end else begin
        timeout_cnt_r <= timeout_cnt_r;
      end
    end
  end

  assign step_total  = step_total_r;
  assign timeout_cnt = timeout_cnt_r;
`endif

endmodule

// File: tb/tb_mmcm_ps_ctrl.sv
// tb_mmcm_ps_ctrl: self-checking bench for mmcm_ps_ctrl. An MMCM responder
// answers each psen with psdone after a (random or fixed) delay; a
// modular-arithmetic model of the phase position predicts every update.
module tb_mmcm_ps_ctrl;

  localparam int SPC = 448;
  localparam int TO  = 64;

  logic        clk;
  logic        rst_n;
  logic        locked;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_steps;
  logic        clear_err;
  logic        psen;
  logic        psincdec;
  logic        psdone;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic [15:0] position;
`ifdef MMCM_PS_CTRL_STATS_EN
  logic [31:0] step_total;
  logic [15:0] timeout_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int model_pos = 0;

  // responder / monitor state
  int cyc = 0;
  int resp_en = 1;
  int dmin = 1;
  int dmax = 1;
  int cd = 0;
  int done_total = 0;
  int double_psen = 0;
  bit outst = 1'b0;

  mmcm_ps_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .locked     (locked),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_steps  (req_steps),
    .clear_err  (clear_err),
    .psen       (psen),
    .psincdec   (psincdec),
    .psdone     (psdone),
    .busy       (busy),
    .done       (done),
    .err_timeout(err_timeout),
`ifdef MMCM_PS_CTRL_STATS_EN
    .step_total (step_total),
    .timeout_cnt(timeout_cnt),
`endif
    .position   (position)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MMCM responder and monitor, acting 1 time unit after each rising edge
  initial begin
    psdone = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      psdone = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) psdone = 1'b1;
      end
      if (psdone || !rst_n || !locked || err_timeout) outst = 1'b0;
      if (done === 1'b1) done_total++;
      if (psen === 1'b1) begin
        if (outst) double_psen++;
        outst = 1'b1;
        if (resp_en != 0) cd = $urandom_range(dmax, dmin);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (req_ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: req_ready=%b, required 1", req_ready);
    end
  endtask

  // Issue one request and follow it to done, checking each position update.
  task automatic do_request(input int steps, input int gap, input int bound);
    int n_psen = 0;
    int first_psen = -1;
    int last_psen = -1;
    int acc;
    int mag;
    bit outs = 1'b0;
    bit pend = 1'b0;
    bit fin = 1'b0;
    logic [31:0] sv;
    mag = (steps < 0) ? -steps : steps;
    wait_ready();
    sv = steps;
    req_valid = 1'b1;
    req_steps = sv[11:0];
    acc = cyc;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < bound && !fin; k++) begin
      if (pend) begin
        checks++;
        if (position !== model_pos[15:0]) begin
          errors++;
          $display("FAIL step_pos(%0d): position=%0d, required %0d", steps, position, model_pos);
        end
        pend = 1'b0;
      end
      if (psen === 1'b1) begin
        if (n_psen == 0) begin
          first_psen = cyc;
          checks++;
          if (psincdec !== (steps >= 0)) begin
            errors++;
            $display("FAIL psincdec(%0d): got %b, required %b", steps, psincdec, steps >= 0);
          end
        end else if (gap > 0) begin
          checks++;
          if (cyc - last_psen != gap) begin
            errors++;
            $display("FAIL psen_gap(%0d): got %0d cycles, required %0d", steps, cyc - last_psen, gap);
          end
        end
        last_psen = cyc;
        n_psen++;
        outs = 1'b1;
      end
      if (psdone === 1'b1 && outs) begin
        model_pos = (model_pos + ((steps > 0) ? 1 : SPC - 1)) % SPC;
        pend = 1'b1;
        outs = 1'b0;
      end
      if (done === 1'b1) fin = 1'b1;
      else tick();
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL done_timeout(%0d): no done within %0d cycles, required done", steps, bound);
    end
    checks++;
    if (n_psen != mag) begin
      errors++;
      $display("FAIL psen_count(%0d): got %0d, required %0d", steps, n_psen, mag);
    end
    if (mag != 0) begin
      checks++;
      if (first_psen != acc + 1) begin
        errors++;
        $display("FAIL psen_latency(%0d): first psen cycle %0d, required %0d", steps, first_psen, acc + 1);
      end
    end
    checks++;
    if (position !== model_pos[15:0]) begin
      errors++;
      $display("FAIL final_pos(%0d): position=%0d, required %0d", steps, position, model_pos);
    end
    tick();
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_done(%0d): done=%b req_ready=%b, required 0 1", steps, done, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    locked = 1'b1;
    req_valid = 1'b0;
    req_steps = 12'd0;
    clear_err = 1'b0;
    tick();
    tick();
    checks++;
    if ({req_ready, psen, psincdec, busy, done, err_timeout} !== 6'b0 || position !== 16'd0) begin
      errors++;
      $display("FAIL reset_vals: rdy/psen/dir/busy/done/err=%b pos=%0d, required 000000 0",
               {req_ready, psen, psincdec, busy, done, err_timeout}, position);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: req_ready=%b busy=%b, required 1 0", req_ready, busy);
    end
    model_pos = 0;
  endtask

  task automatic test_single_inc();
    dmin = 12;
    dmax = 12;
    do_request(3, 13, 200);
    checks++;
    if (position !== 16'd3) begin
      errors++;
      $display("FAIL single_inc_pos: position=%0d, required 3", position);
    end
  endtask

  task automatic test_neg_wrap();
    dmin = 1;
    dmax = 4;
    do_request(-3, 0, 100);
    do_request(-2, 0, 100);
    checks++;
    if (position !== 16'd446) begin
      errors++;
      $display("FAIL neg_wrap_pos: position=%0d, required 446", position);
    end
  endtask

  task automatic test_pos_wrap();
    dmin = 1;
    dmax = 1;
    do_request(2, 0, 100);
    do_request(447, 2, 1200);
    do_request(1, 0, 50);
    checks++;
    if (position !== 16'd0) begin
      errors++;
      $display("FAIL pos_wrap: position=%0d, required 0", position);
    end
    do_request(-2048, 2, 5000);
  endtask

  task automatic test_random();
    dmin = 1;
    dmax = 5;
    for (int i = 0; i < 6; i++) begin
      do_request(int'($urandom_range(80, 0)) - 40, 0, 600);
    end
  endtask

  task automatic test_timeout();
    int p;
    int d0;
    dmin = 1;
    dmax = 1;
    resp_en = 0;
    d0 = done_total;
    wait_ready();
    req_valid = 1'b1;
    req_steps = 12'd1;
    tick();
    req_valid = 1'b0;
    p = cyc;
    checks++;
    if (psen !== 1'b1) begin
      errors++;
      $display("FAIL to_psen: psen=%b, required 1", psen);
    end
    while (cyc < p + TO) tick();
    checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_early: err=%b busy=%b at psen+%0d, required 0 1", err_timeout, busy, TO);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_set: err=%b rdy=%b busy=%b, required 1 0 1", err_timeout, req_ready, busy);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (psen !== 1'b0 || busy !== 1'b1 || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL fault_hold: psen=%b busy=%b err=%b, required 0 1 1", psen, busy, err_timeout);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || done_total != d0) begin
      errors++;
      $display("FAIL to_clear: err=%b busy=%b rdy=%b dones=%0d, required 0 0 1 %0d",
               err_timeout, busy, req_ready, done_total, d0);
    end
    // Second timeout: lock loss keeps the flag, clear_err in IDLE drops it.
    req_valid = 1'b1;
    req_steps = 12'hFFF;
    tick();
    req_valid = 1'b0;
    while (err_timeout !== 1'b1 && cyc < p + 400) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    tick();
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_retain: err=%b busy=%b rdy=%b, required 1 0 1", err_timeout, busy, req_ready);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if (err_timeout !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_clear: err=%b rdy=%b, required 0 1", err_timeout, req_ready);
    end
    resp_en = 1;
  endtask

  task automatic test_lock_loss();
    int seen = 0;
    int k = 0;
    int d0;
    dmin = 3;
    dmax = 3;
    d0 = done_total;
    wait_ready();
    req_valid = 1'b1;
    req_steps = 12'd10;
    tick();
    req_valid = 1'b0;
    while (seen < 5 && k < 200) begin
      if (psdone === 1'b1) seen++;
      if (seen < 5) tick();
      k++;
    end
    tick();
    locked = 1'b0;
    tick();
    checks++;
    if (position !== 16'd0 || busy !== 1'b0 || req_ready !== 1'b0 || psen !== 1'b0) begin
      errors++;
      $display("FAIL lock_loss: pos=%0d busy=%b rdy=%b psen=%b, required 0 0 0 0",
               position, busy, req_ready, psen);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (position !== 16'd0 || psen !== 1'b0) begin
        errors++;
        $display("FAIL lock_stray: pos=%0d psen=%b, required 0 0", position, psen);
      end
    end
    locked = 1'b1;
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b1 || done_total != d0 || position !== 16'd0) begin
      errors++;
      $display("FAIL lock_resume: rdy=%b dones=%0d pos=%0d, required 1 %0d 0",
               req_ready, done_total, position, d0);
    end
    model_pos = 0;
  endtask

  task automatic test_zero_b2b();
    int k = 0;
    dmin = 2;
    dmax = 2;
    wait_ready();
    req_valid = 1'b1;
    req_steps = 12'd0;
    tick();
    req_steps = 12'd1;
    checks++;
    if (done !== 1'b1 || psen !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: done=%b psen=%b rdy=%b busy=%b, required 1 0 0 1",
               done, psen, req_ready, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1 || psen !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: done=%b rdy=%b psen=%b busy=%b, required 0 1 0 0",
               done, req_ready, psen, busy);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (psen !== 1'b1 || busy !== 1'b1 || psincdec !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: psen=%b busy=%b dir=%b, required 1 1 1", psen, busy, psincdec);
    end
    while (done !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    model_pos = (model_pos + 1) % SPC;
    checks++;
    if (done !== 1'b1 || position !== model_pos[15:0]) begin
      errors++;
      $display("FAIL b2b_done: done=%b pos=%0d, required 1 %0d", done, position, model_pos);
    end
  endtask

  task automatic test_async_reset();
    dmin = 4;
    dmax = 4;
    wait_ready();
    req_valid = 1'b1;
    req_steps = 12'd6;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, psen, psincdec, busy, done, err_timeout} !== 6'b0 || position !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: rdy/psen/dir/busy/done/err=%b pos=%0d, required 000000 0",
               {req_ready, psen, psincdec, busy, done, err_timeout}, position);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || position !== 16'd0) begin
      errors++;
      $display("FAIL reset_recover: rdy=%b busy=%b pos=%0d, required 1 0 0", req_ready, busy, position);
    end
  endtask

  initial begin
    test_reset();
    test_single_inc();
    test_neg_wrap();
    test_pos_wrap();
    test_random();
    test_timeout();
    test_lock_loss();
    test_zero_b2b();
    test_async_reset();
    checks++;
    if (double_psen != 0) begin
      errors++;
      $display("FAIL psen_handshake: %0d psen pulses without intervening psdone, required 0", double_psen);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmcm_ps_ctrl.md
# mmcm_ps_ctrl

Sequencer for the ADC MMCM dynamic fine phase shift port. It converts a signed step request into a train of single-cycle `psen` pulses, each handshaked against `psdone`, and tracks the resulting phase position modulo one output period. It sits beside the ADC MMCM in the clock subsystem, in the MMCM phase-shift clock domain, and lets software align the 125/250 MHz ADC clocks to the cleaner output.

## Interface
- `STEP_W`, 12: width of the signed request `req_steps`.
- `POS_W`, 16: width of the `position` output.
- `STEPS_PER_CYCLE`, 448: fine steps per output clock period, which is the wrap point of `position`. Must satisfy `STEPS_PER_CYCLE` < 2^`POS_W`.
- `TIMEOUT`, 64: maximum cycles spent in WAIT without `psdone`.

- `clk` in 1: phase-shift clock, the same clock as the MMCM `psclk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `locked` in 1: MMCM locked. Already synchronous to `clk`.
- `req_valid` in 1: step request valid.
- `req_ready` out 1: controller can accept a request.
- `req_steps` in `STEP_W`: signed two's-complement step count. Positive values increment phase.
- `clear_err` in 1: clears the sticky `err_timeout` flag.
- `psen` out 1: MMCM phase-shift enable. Single-cycle pulse.
- `psincdec` out 1: MMCM direction. 1 means increment.
- `psdone` in 1: MMCM phase-shift complete.
- `busy` out 1: a request is in progress.
- `done` out 1: single-cycle pulse when a request completes.
- `err_timeout` out 1: sticky flag, set when `psdone` does not arrive within `TIMEOUT` cycles.
- `position` out `POS_W`: accumulated phase, in the range 0..`STEPS_PER_CYCLE`-1.

## Operation
- **States:** IDLE, PULSE, WAIT, FINISH, FAULT.
- **IDLE:** `req_ready` = `locked`. On `req_valid & req_ready`:
  - latch `remaining` = |`req_steps|`, held as `STEP_W` bits unsigned. The value -2^(`STEP_W`-1) gives magnitude 2^(`STEP_W`-1).
  - latch `dir` = ~`req_steps`[MSB].
  - go to PULSE, or to FINISH if the magnitude is 0.
- **PULSE:** `psen` = 1 for this one cycle. `psincdec` = `dir` (held stable in all non-IDLE states). Clear the timeout counter. Go to WAIT.
- **WAIT:** `psdone` is sampled only in this state.
  - On `psdone`: `remaining` decrements and `position` updates.
    - Increment: `position` = `position`+1, wrapping `STEPS_PER_CYCLE`-1 → 0.
    - Decrement: `position` = `position`-1, wrapping 0 → `STEPS_PER_CYCLE`-1.
  - After the update, go to PULSE if `remaining` ≠ 0, otherwise go to FINISH.
  - If the counter reaches `TIMEOUT` without `psdone`: set `err_timeout` and go to FAULT.
- **FINISH:** `done` = 1 for one cycle. Go to IDLE.
- **FAULT:** `busy` = 1 and `req_ready` = 0. Leave to IDLE on `clear_err`, which also clears `err_timeout`. `done` is not pulsed.
- **Loss of lock:** if `locked` = 0 in any state, the next state is IDLE.
  - `position` is set to 0, because the MMCM reset discards the phase.
  - `remaining` is set to 0 and the pending request is discarded.
  - `done` is not pulsed. `err_timeout` is retained.
- **Simultaneous `psdone` and lock loss:** lock loss wins. `position` = 0.
- **`clear_err` outside FAULT:** still clears `err_timeout`. No other effect.
- `busy` = 1 in PULSE, WAIT, FINISH and FAULT.

## Timing
- All outputs are registered.
- Reset values: `req_ready` = 0, `psen` = 0, `psincdec` = 0, `busy` = 0, `done` = 0, `err_timeout` = 0, `position` = 0, state IDLE.
- Request accepted in cycle 0 → `psen` high in cycle 1.
- `psen` in cycle t and `psdone` in cycle t+d (d ≥ 1) → next `psen` at t+d+1.
  - Each step costs d+1 cycles.
  - `position` shows the updated value from t+d+1.
- Last `psdone` in cycle u → `done` in cycle u+1 → `req_ready` in cycle u+2.
- Zero-step request accepted in cycle 0 → `done` in cycle 1. No `psen`.
- Timeout: `err_timeout` rises `TIMEOUT`+1 cycles after the `psen` cycle.
- `psen` is never asserted twice without an intervening `psdone`.
- `rst_n` asserted mid-request: all outputs return to reset values asynchronously.

## Configuration
- Macro `MMCM_PS_CTRL_STATS_EN` defined adds two outputs:
  - `step_total` out 32: count of completed steps. It increments on each accepted `psdone`, wraps at 2^32, and is reset only by `rst_n`.
  - `timeout_cnt` out 16: count of timeout events. It saturates at 0xFFFF.
- Macro undefined: these ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package `clock_pkg` holds:
  - the `ps_state_t` enum (IDLE, PULSE, WAIT, FINISH, FAULT);
  - the default `STEPS_PER_CYCLE` and `TIMEOUT` constants.
- No sub-module. The position wrap arithmetic is an inline function in `clock_pkg`.

## Test plan
- **Single increment:** `locked` = 1, `req_steps` = +3, bench model returns `psdone` 12 cycles after each `psen` → 3 `psen` pulses 13 cycles apart, `psincdec` = 1, `position` = 3, `done` once.
- **Negative wrap:** `position` = 0, `req_steps` = -2 → `position` 447 then 446, `psincdec` = 0.
- **Positive wrap and full magnitude:** preload `position` to 447 with +447 steps, then request +1 → `position` = 0. Separately, `req_steps` = -2048 → exactly 2048 pulses.
- **Timeout:** `psdone` never returned after `psen` → `err_timeout` = 1 at cycle `TIMEOUT`+1, `req_ready` = 0. `clear_err` → IDLE, `req_ready` = 1.
- **Lock loss:** drop `locked` after 5 of 10 steps → `position` = 0, no `done`. A `psdone` arriving later is ignored.
- **Zero step and back-to-back:** `req_steps` = 0 → `done` in cycle 1, no `psen`. Next request accepted at cycle 2. `req_valid` held high across FINISH is not accepted until IDLE.
